// File: rtl/pipe_addsub_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_addsub_pkg : full-adder cell and skew-buffer layout helper
// Rev 1.0
// ------------------------------------------------------------------
package pipe_addsub_pkg;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  // Chunk offset of the operand-B chunks parked behind stage k.
  function automatic int btri_base(input int k, input int stages);
    int n;
    n = 0;
    for (int i = 0; i < k; i++) n += stages - 1 - i;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_chunk.sv
`default_nettype none
// ------------------------------------------------------------------
// addsub_chunk : CW-bit ripple-carry adder from full-adder cells
// Rev 1.0
// ------------------------------------------------------------------
module addsub_chunk
  import pipe_addsub_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          c_msb
);

  logic [1:0] w_fa;
  logic       w_c;

  always_comb begin
    w_c   = ci;
    c_msb = ci;
    s     = '0;
    w_fa  = '0;
    for (int i = 0; i < CW; i++) begin
      if (i == CW - 1) c_msb = w_c;
      w_fa = full_add(a[i], b[i], w_c);
      s[i] = w_fa[0];
      w_c  = w_fa[1];
    end
    co = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_addsub : STAGES-deep chunked add/sub with valid/ready handshake
// Rev 1.0
// ------------------------------------------------------------------
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_CW = WIDTH / STAGES;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
    $error("pipe_addsub: WIDTH must be a positive multiple of STAGES");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_bc;
  logic             w_c0;
  logic [WIDTH-1:0] w_nx [STAGES];
  logic [STAGES-1:0] w_co;
  logic [STAGES-1:0] w_v_nx;
  logic             w_ovf_nx;

  // Stage k word: result chunks 0..k below, still-unused A chunks above.
  logic [WIDTH-1:0] r_as [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic             r_ovf;

  assign w_adv     = !r_v[STAGES-1] || out_ready;
  assign in_ready  = w_adv;
  assign w_bc      = b ^ {WIDTH{sub}};
  assign w_c0      = sub | cin;
  assign out_valid = r_v[STAGES-1];
  assign sum       = r_as[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

  always_comb begin
    w_v_nx    = r_v << 1;
    w_v_nx[0] = in_valid;
  end

  if (STAGES == 1) begin : g_single
    logic [WIDTH-1:0] w_s;
    logic             w_cm;

    addsub_chunk #(.CW(WIDTH)) u_chunk (
      .a     (a),
      .b     (w_bc),
      .ci    (w_c0),
      .s     (w_s),
      .co    (w_co[0]),
      .c_msb (w_cm)
    );

    assign w_nx[0]  = w_s;
    assign w_ovf_nx = w_co[0] ^ w_cm;
  end else begin : g_multi
    localparam int c_BTRI_W = btri_base(STAGES - 1, STAGES) * c_CW;

    logic [c_BTRI_W-1:0] w_bt_nx;
    logic [c_BTRI_W-1:0] r_bt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_bt <= '0;
      else if (w_adv) r_bt <= w_bt_nx;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int c_BOFF  = btri_base(k, STAGES) * c_CW;
      localparam int c_BPREV = btri_base(k - 1, STAGES) * c_CW;

      logic [WIDTH-1:0] w_in;
      logic [WIDTH-1:0] w_word;
      logic [c_CW-1:0]  w_bk;
      logic [c_CW-1:0]  w_s;
      logic             w_ci;
      logic             w_cm;

      if (k == 0) begin : g_first
        assign w_in = a;
        assign w_bk = w_bc[c_CW-1:0];
        assign w_ci = w_c0;
        assign w_bt_nx[c_BOFF +: (STAGES-1)*c_CW] = w_bc[WIDTH-1:c_CW];
      end else begin : g_next
        assign w_in = r_as[k-1];
        assign w_bk = r_bt[c_BPREV +: c_CW];
        assign w_ci = r_c[k-1];
        if (k < STAGES - 1) begin : g_fwd
          assign w_bt_nx[c_BOFF +: (STAGES-1-k)*c_CW] =
            r_bt[c_BPREV + c_CW +: (STAGES-1-k)*c_CW];
        end
      end

      addsub_chunk #(.CW(c_CW)) u_chunk (
        .a     (w_in[k*c_CW +: c_CW]),
        .b     (w_bk),
        .ci    (w_ci),
        .s     (w_s),
        .co    (w_co[k]),
        .c_msb (w_cm)
      );

      always_comb begin
        w_word                   = w_in;
        w_word[k*c_CW +: c_CW]   = w_s;
      end
      assign w_nx[k] = w_word;

      if (k == STAGES - 1) begin : g_msb
        assign w_ovf_nx = w_co[k] ^ w_cm;
      end else begin : g_mid
        logic w_cm_unused;
        assign w_cm_unused = w_cm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < STAGES; k++) r_as[k] <= '0;
    end else if (w_adv) begin
      r_v   <= w_v_nx;
      r_c   <= w_co;
      r_ovf <= w_ovf_nx;
      for (int k = 0; k < STAGES; k++) r_as[k] <= w_nx[k];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pipe_addsub : directed bench for STAGES = 4, 1 and 16 side by side
// Rev 1.0
// ------------------------------------------------------------------
module tb_pipe_addsub;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  co;
  logic [2:0]  of;
  logic [15:0] sm [3];

  vec_t vt [16];
  int   cur;
  int   cyc;
  logic lat_on;
  int   n_chk;
  int   n_pass;
  int   fq_idx [3][64];
  int   fq_t   [3][64];
  int   wr [3];
  int   rd [3];

  pipe_addsub #(.WIDTH(16), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[0]),
    .out_ready(out_ready), .sum(sm[0]), .cout(co[0]), .ovf(of[0])
  );

  pipe_addsub #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[1]),
    .out_ready(out_ready), .sum(sm[1]), .cout(co[1]), .ovf(of[1])
  );

  pipe_addsub #(.WIDTH(16), .STAGES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[2]),
    .out_ready(out_ready), .sum(sm[2]), .cout(co[2]), .ovf(of[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int stg(input int x);
    return (x == 0) ? 4 : (x == 1) ? 1 : 16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Per-DUT scoreboard of accepted vector indices, checked in arrival order.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int x = 0; x < 3; x++) begin
        wr[x] <= 0;
        rd[x] <= 0;
      end
    end else begin
      for (int x = 0; x < 3; x++) begin
        if (ov[x] && out_ready) begin
          if (rd[x] == wr[x]) begin
            chk($sformatf("s%0d_unexpected_out", stg(x)), 32'(ov[x]), 32'd0);
          end else begin
            chk($sformatf("s%0d_sum_v%0d", stg(x), fq_idx[x][rd[x]]),
                32'(sm[x]), 32'(vt[fq_idx[x][rd[x]]].s));
            chk($sformatf("s%0d_cout_v%0d", stg(x), fq_idx[x][rd[x]]),
                32'(co[x]), 32'(vt[fq_idx[x][rd[x]]].c));
            chk($sformatf("s%0d_ovf_v%0d", stg(x), fq_idx[x][rd[x]]),
                32'(of[x]), 32'(vt[fq_idx[x][rd[x]]].v));
            if (lat_on)
              chk($sformatf("s%0d_latency_v%0d", stg(x), fq_idx[x][rd[x]]),
                  32'(cyc + 1 - fq_t[x][rd[x]]), 32'(stg(x)));
            rd[x] <= rd[x] + 1;
          end
        end
        if (in_valid && ir[x]) begin
          fq_idx[x][wr[x]] <= cur;
          fq_t[x][wr[x]]   <= cyc + 1;
          wr[x]            <= wr[x] + 1;
        end
      end
    end
  end

  task automatic send(input int i);
    cur      = i;
    a        = vt[i].a;
    b        = vt[i].b;
    cin      = vt[i].cin;
    sub      = vt[i].sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    //            a         b         cin   sub   sum       cout  ovf
    vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[4]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[5]  = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};
    vt[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[7]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[8]  = '{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0};
    vt[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vt[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[12] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    vt[13] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[14] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[15] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    n_chk     = 0;
    n_pass    = 0;
    cur       = 0;
    lat_on    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    for (int x = 0; x < 3; x++) begin
      chk($sformatf("s%0d_rst_sum", stg(x)), 32'(sm[x]), 32'd0);
      chk($sformatf("s%0d_rst_cout", stg(x)), 32'(co[x]), 32'd0);
      chk($sformatf("s%0d_rst_ovf", stg(x)), 32'(of[x]), 32'd0);
      chk($sformatf("s%0d_rst_out_valid", stg(x)), 32'(ov[x]), 32'd0);
    end
    rst_n = 1'b1;
    chk("in_ready_after_rst", 32'(ir), 32'h7);

    // Isolated corner vectors, then an eight-beat back-to-back stream.
    lat_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(i);
      idle(20);
    end
    for (int i = 4; i < 12; i++) send(i);
    idle(20);
    lat_on = 1'b0;

    // Fill the 4-stage pipe with the sink stalled, then hold for five cycles.
    out_ready = 1'b0;
    for (int i = 12; i < 16; i++) send(i);
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(ir[0]), 32'd0);
      chk("stall_out_valid", 32'(ov[0]), 32'd1);
      chk("stall_sum", 32'(sm[0]), 32'h0003);
      chk("stall_cout", 32'(co[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(25);

    // Reset with three beats in flight.
    send(4);
    send(5);
    send(6);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    for (int x = 0; x < 3; x++) begin
      chk($sformatf("s%0d_midrst_sum", stg(x)), 32'(sm[x]), 32'd0);
      chk($sformatf("s%0d_midrst_cout", stg(x)), 32'(co[x]), 32'd0);
      chk($sformatf("s%0d_midrst_ovf", stg(x)), 32'(of[x]), 32'd0);
      chk($sformatf("s%0d_midrst_out_valid", stg(x)), 32'(ov[x]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(ov), 32'd0);
    end
    @(posedge clk);
    #1;
    lat_on = 1'b1;
    send(0);
    idle(20);
    lat_on = 1'b0;

    for (int x = 0; x < 3; x++)
      chk($sformatf("s%0d_undelivered", stg(x)), 32'(wr[x] - rd[x]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
